// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_arbiter
// Description : Two-port req/ack arbiter sharing one single-port synchronous
//               data memory (port 0 = core LSU, port 1 = loader). Optional
//               round-robin conflict resolution is enabled by ARB_RR_EN.
// Revision    : 1.0
// ============================================================================
module data_mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [31:0]       addr0,
    input  logic [31:0]       addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              core_stall,
    output logic [1:0]        gnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic              w_sel1;
    logic              w_start;
    logic              w_unused;

    // Only the word-address bits of the byte address reach the memory.
    assign w_unused = ^{addr0[31:ADDR_W+2], addr0[1:0], addr1[31:ADDR_W+2], addr1[1:0]};
    assign w_start  = (state_q == S_IDLE) && (req0 || req1);

`ifdef ARB_RR_EN
    logic rr_last_q, rr_last_d;

    // On conflict the port that was not granted last time wins.
    assign w_sel1    = req1 && (!req0 || !rr_last_q);
    assign rr_last_d = w_start ? w_sel1 : rr_last_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_last_q <= 1'b1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`else
    assign w_sel1 = req1;
`endif

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        wr_d        = wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (w_start) begin
                    state_d     = S_BUSY;
                    gnt_d       = w_sel1 ? 2'b10 : 2'b01;
                    mem_en_d    = 1'b1;
                    mem_we_d    = w_sel1 ? we1 : we0;
                    wr_d        = w_sel1 ? we1 : we0;
                    mem_addr_d  = w_sel1 ? addr1[ADDR_W+1:2] : addr0[ADDR_W+1:2];
                    mem_wdata_d = w_sel1 ? wdata1 : wdata0;
                end
            end
            S_BUSY: begin
                state_d = S_RESP;
                ack0_d  = gnt_q[0];
                ack1_d  = gnt_q[1];
            end
            S_RESP: begin
                state_d = S_IDLE;
                gnt_d   = 2'b00;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            gnt_q       <= 2'b00;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            wr_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            wr_q        <= wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Read data passes straight through during the ack cycle; writes return 0.
    assign rdata0     = (ack0_q && !wr_q) ? mem_rdata : '0;
    assign rdata1     = (ack1_q && !wr_q) ? mem_rdata : '0;
    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign core_stall = req0 && !ack0_q;
    assign gnt        = gnt_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_arbiter
// Description : Directed scoreboard bench for data_mem_arbiter with a
//               behavioural single-port memory (ARB_RR_EN aware).
// Revision    : 1.0
// ============================================================================
module tb_data_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [31:0] rdata0, rdata1;
    logic        ack0, ack1, core_stall;
    logic [1:0]  gnt;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] mem [0:255];

    typedef struct packed {
        logic        p;
        logic [31:0] rd;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    bit   last_gnt = 1'b1;
`ifdef ARB_RR_EN
    bit   rr_mode = 1'b1;
`else
    bit   rr_mode = 1'b0;
`endif

    data_mem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .rdata0(rdata0), .rdata1(rdata1), .ack0(ack0), .ack1(ack1),
        .core_stall(core_stall), .gnt(gnt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for an ack, then compares it against the scoreboard head.
    task automatic wait_ack(input string tag, output int cyc);
        exp_t e;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(ack0 || ack1) && cyc < 12);
        check({tag, "_ack_seen"}, {31'd0, ack0 | ack1}, 32'd1);
        if (ack0 || ack1) begin
            check({tag, "_sb_nonempty"}, {31'd0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({tag, "_port"}, {31'd0, ack1}, {31'd0, e.p});
                check({tag, "_rdata"}, ack1 ? rdata1 : rdata0, e.rd);
                check({tag, "_other_rdata"}, ack1 ? rdata0 : rdata1, 32'd0);
            end
        end
    endtask

    task automatic do_access(input bit p, input bit w, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] exp_rd,
                             input string tag);
        int cyc;
        if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = wd; end
        else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = wd; end
        sb.push_back('{p, w ? 32'd0 : exp_rd});
        @(negedge clk);
        check({tag, "_gnt_c1"}, {30'd0, gnt}, p ? 32'd2 : 32'd1);
        check({tag, "_mem_en_c1"}, {31'd0, mem_en}, 32'd1);
        check({tag, "_mem_we_c1"}, {31'd0, mem_we}, {31'd0, w});
        check({tag, "_mem_addr_c1"}, {24'd0, mem_addr}, {24'd0, a[9:2]});
        if (w) check({tag, "_mem_wdata_c1"}, mem_wdata, wd);
        wait_ack(tag, cyc);
        check({tag, "_latency"}, cyc, 32'd1);
        check({tag, "_gnt_c2"}, {30'd0, gnt}, p ? 32'd2 : 32'd1);
        if (p) req1 = 1'b0; else req0 = 1'b0;
        last_gnt = p;
        @(negedge clk);
        check({tag, "_idle_gnt"}, {30'd0, gnt}, 32'd0);
        check({tag, "_idle_ack"}, {30'd0, ack1, ack0}, 32'd0);
    endtask

    initial begin
        int   cyc;
        bit   win;
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) @(negedge clk);
        check("rst_gnt", {30'd0, gnt}, 32'd0);
        check("rst_ack", {30'd0, ack1, ack0}, 32'd0);
        check("rst_mem_en_we", {30'd0, mem_en, mem_we}, 32'd0);
        check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Loader write then core read-back of the same word.
        do_access(1'b1, 1'b1, 32'h64, 32'd25, 32'd0, "t1_wr");
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h64;
        sb.push_back('{1'b0, 32'd25});
        #1 check("t2_stall_c0", {31'd0, core_stall}, 32'd1);
        @(negedge clk);
        check("t2_stall_c1", {31'd0, core_stall}, 32'd1);
        wait_ack("t2_rd", cyc);
        check("t2_latency", cyc, 32'd1);
        check("t2_stall_c2", {31'd0, core_stall}, 32'd0);
        req0 = 1'b0;
        last_gnt = 1'b0;
        @(negedge clk);

        // Simultaneous requests, four rounds.
        for (int k = 0; k < 4; k++) begin
            win = rr_mode ? !last_gnt : 1'b1;
            req0 = 1'b1; we0 = 1'b0; addr0 = 32'h64;
            req1 = 1'b1; we1 = 1'b1; addr1 = 32'h6C; wdata1 = 32'd100 + k;
            sb.push_back('{win, win ? 32'd0 : 32'd25});
            @(negedge clk);
            check("t3_gnt", {30'd0, gnt}, win ? 32'd2 : 32'd1);
            wait_ack("t3_conflict", cyc);
            req0 = 1'b0; req1 = 1'b0;
            last_gnt = win;
            @(negedge clk);
        end

        // Core request arrives while the loader owns the memory.
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h70; wdata1 = 32'd7;
        sb.push_back('{1'b1, 32'd0});
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h70;
        sb.push_back('{1'b0, 32'd7});
        #1 check("t4_stall_busy", {31'd0, core_stall}, 32'd1);
        wait_ack("t4_ldr", cyc);
        check("t4_ldr_latency", cyc, 32'd1);
        req1 = 1'b0;
        check("t4_stall_resp", {31'd0, core_stall}, 32'd1);
        wait_ack("t4_core", cyc);
        check("t4_core_latency", cyc, 32'd3);
        check("t4_stall_ack", {31'd0, core_stall}, 32'd0);
        req0 = 1'b0;
        last_gnt = 1'b0;
        @(negedge clk);

        // Request dropped before ack still completes.
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h64;
        sb.push_back('{1'b0, 32'd25});
        @(negedge clk);
        req0 = 1'b0;
        wait_ack("t_drop", cyc);
        check("t_drop_latency", cyc, 32'd1);
        @(negedge clk);

        // Reset during BUSY abandons the write.
        do_access(1'b1, 1'b1, 32'h60, 32'hAA, 32'd0, "t5_pre");
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h60; wdata1 = 32'hBB;
        @(negedge clk);
        check("t5_busy_we", {31'd0, mem_we}, 32'd1);
        reset = 1'b1;
        #1;
        check("t5_rst_we", {30'd0, mem_en, mem_we}, 32'd0);
        check("t5_rst_gnt", {30'd0, gnt}, 32'd0);
        req1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_no_ack", {30'd0, ack1, ack0}, 32'd0);
        end
        reset = 1'b0;
        last_gnt = 1'b1;
        @(negedge clk);
        check("t5_no_ack_rel", {30'd0, ack1, ack0}, 32'd0);
        do_access(1'b0, 1'b0, 32'h60, 32'd0, 32'hAA, "t5_rb");

        // Address wrap and ignored byte-offset bits.
        do_access(1'b0, 1'b1, 32'h0, 32'h5A5A, 32'd0, "t6_wr0");
        do_access(1'b0, 1'b0, 32'h0000_0403, 32'd0, 32'h5A5A, "t6_wrap");

        check("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
